// File: rtl/select_multi_grant_node_pkg.sv
// Shared constants, pick record and helpers for the multi-grant select node.
package select_pkg;

  localparam int SIZE_SELECT_BLOCK_DEF = 16;
  localparam int NUM_GRANTS_DEF        = 2;
  localparam int STARVE_LIMIT_DEF      = 15;

  // Wide enough for any legal block size (up to 64 requests).
  localparam int IDX_W = 6;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             vld;
  } pick_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
    int t;
    t = int'(i) + 1;
    if (t >= n) t = 0;
    return IDX_W'(t);
  endfunction

endpackage

// File: rtl/select_multi_grant_node_if.sv
// Request/grant bundle between a select node and its neighbouring tree stages.
interface select_multi_grant_node_if #(
  parameter int SIZE_SELECT_BLOCK = 16,
  parameter int NUM_GRANTS        = 2
);
  logic [SIZE_SELECT_BLOCK-1:0] req_i;
  logic [NUM_GRANTS-1:0]        grant_i;
  logic [SIZE_SELECT_BLOCK-1:0] grant_o;
  logic [NUM_GRANTS-1:0]        req_o;

  modport master (output req_i, output grant_i, input grant_o, input req_o);
  modport slave  (input req_i, input grant_i, output grant_o, output req_o);
endinterface

// File: rtl/select_multi_grant_node_rotate_pick.sv
// Circular first-set scan from a start index, skipping masked requests.
module rotate_pick
  import select_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic [N-1:0]     excl_i,
  output pick_t            pick_o
);

  logic [N-1:0] avail;
  int           j;

  assign avail = req_i & ~excl_i;

  // Scan from the far end so the smallest offset from start_i wins.
  always_comb begin
    pick_o = '0;
    j      = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = int'(start_i) + off;
      if (j >= N) j = j - N;
      if (avail[j]) begin
        pick_o.idx = IDX_W'(j);
        pick_o.vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/select_multi_grant_node.sv
// Multi-grant round-robin select node; optional anti-starvation guard
// enabled by defining SELECT_STARVE_GUARD_EN.
module select_multi_grant_node
  import select_pkg::*;
#(
  parameter int SIZE_SELECT_BLOCK = SIZE_SELECT_BLOCK_DEF,
  parameter int NUM_GRANTS        = NUM_GRANTS_DEF,
  parameter int STARVE_LIMIT      = STARVE_LIMIT_DEF
) (
  input logic                      clk,
  input logic                      reset,
  select_multi_grant_node_if.slave bus
);

  localparam int PW = clog2(SIZE_SELECT_BLOCK);

  logic [SIZE_SELECT_BLOCK-1:0] req;
  logic [SIZE_SELECT_BLOCK-1:0] grant_raw;
  logic [SIZE_SELECT_BLOCK-1:0] grant;
  logic [NUM_GRANTS-1:0]        req_cnt;
  logic [PW-1:0]                rr_ptr_q, rr_ptr_d;
  logic                         starve_any;
  logic [IDX_W-1:0]             starve_idx;
  logic [SIZE_SELECT_BLOCK-1:0] slot_oh  [NUM_GRANTS];
  logic [IDX_W-1:0]             pick_idx [NUM_GRANTS];
  logic [NUM_GRANTS-1:0]        pick_vld;
  int                           cnt;

  assign req = bus.req_i;

`ifdef SELECT_STARVE_GUARD_EN
  localparam int AW = clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] age_q [SIZE_SELECT_BLOCK];
  logic [AW-1:0] age_d [SIZE_SELECT_BLOCK];

  always_comb begin
    starve_any = 1'b0;
    starve_idx = '0;
    for (int i = 0; i < SIZE_SELECT_BLOCK; i++) begin
      if (!req[i] || grant[i]) age_d[i] = '0;
      else if (age_q[i] != AW'(STARVE_LIMIT)) age_d[i] = age_q[i] + 1'b1;
      else age_d[i] = age_q[i];
    end
    // A counter can sit at the limit for a request that just dropped; require req.
    for (int i = SIZE_SELECT_BLOCK - 1; i >= 0; i--) begin
      if (req[i] && age_q[i] == AW'(STARVE_LIMIT)) begin
        starve_any = 1'b1;
        starve_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE_SELECT_BLOCK; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < SIZE_SELECT_BLOCK; i++) age_q[i] <= age_d[i];
    end
  end
`else
  assign starve_any = 1'b0;
  assign starve_idx = '0;
`endif

  for (genvar k = 0; k < NUM_GRANTS; k++) begin : g_slot
    logic [IDX_W-1:0]             start;
    logic [SIZE_SELECT_BLOCK-1:0] excl;
    logic [SIZE_SELECT_BLOCK-1:0] oh;
    pick_t                        rp;
    pick_t                        pk;

    if (k == 0) begin : g_first
      assign start  = IDX_W'(rr_ptr_q);
      assign excl   = '0;
      assign pk.idx = starve_any ? starve_idx : rp.idx;
      assign pk.vld = starve_any | rp.vld;
    end else begin : g_next
      // Behind a starved slot 0, slot 1 restarts the circular scan at the pointer.
      assign start = (k == 1 && starve_any) ? IDX_W'(rr_ptr_q)
                                            : wrap_inc(g_slot[k-1].pk.idx, SIZE_SELECT_BLOCK);
      assign excl  = g_slot[k-1].excl | g_slot[k-1].oh;
      assign pk    = rp;
    end

    rotate_pick #(.N(SIZE_SELECT_BLOCK)) u_pick (
      .req_i   (req),
      .start_i (start),
      .excl_i  (excl),
      .pick_o  (rp)
    );

    assign oh          = pk.vld ? ({{(SIZE_SELECT_BLOCK-1){1'b0}}, 1'b1} << pk.idx) : '0;
    assign slot_oh[k]  = oh;
    assign pick_idx[k] = pk.idx;
    assign pick_vld[k] = pk.vld;
  end

  always_comb begin
    grant_raw = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int k = 0; k < NUM_GRANTS; k++) begin
      if (bus.grant_i[k]) grant_raw = grant_raw | slot_oh[k];
    end
    // Highest granted round-robin slot wins; a starved slot 0 never moves the pointer.
    for (int k = 0; k < NUM_GRANTS; k++) begin
      if (bus.grant_i[k] && pick_vld[k] && !(k == 0 && starve_any))
        rr_ptr_d = PW'(wrap_inc(pick_idx[k], SIZE_SELECT_BLOCK));
    end
  end

  always_comb begin
    cnt = 0;
    for (int i = 0; i < SIZE_SELECT_BLOCK; i++) cnt = cnt + int'(req[i]);
    for (int k = 0; k < NUM_GRANTS; k++) req_cnt[k] = (cnt >= k + 1);
  end

  assign grant       = reset ? grant_raw : '0;
  assign bus.grant_o = grant;
  assign bus.req_o   = req_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_select_multi_grant_node.sv
// Directed-vector scoreboard bench for select_multi_grant_node (16 requests, 2 grants, starve limit 3).
module tb_select_multi_grant_node;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  select_multi_grant_node_if #(.SIZE_SELECT_BLOCK(16), .NUM_GRANTS(2)) bus ();

  select_multi_grant_node #(
    .SIZE_SELECT_BLOCK (16),
    .NUM_GRANTS        (2),
    .STARVE_LIMIT      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] g;
    logic [1:0]  r;
    string       nm;
  } exp_t;

  exp_t exp_q [$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Drive one vector just after the edge; optionally hold reset low for the first half cycle.
  task automatic apply(input logic [15:0] rq, input logic [1:0] gi,
                       input logic [15:0] eg, input logic [1:0] er,
                       input string nm, input bit rst_pulse);
    exp_t x;
    @(posedge clk);
    #1;
    bus.req_i   = rq;
    bus.grant_i = gi;
    if (rst_pulse) reset = 1'b0;
    x.g  = eg;
    x.r  = er;
    x.nm = nm;
    exp_q.push_back(x);
    if (rst_pulse) begin
      @(negedge clk);
      #1;
      reset       = 1'b1;
      bus.grant_i = 2'b00;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.grant_o !== e.g || bus.req_o !== e.r) begin
          n_bad++;
          $display("FAIL %s: got grant_o=%h req_o=%b, expected grant_o=%h req_o=%b",
                   e.nm, bus.grant_o, bus.req_o, e.g, e.r);
        end
      end
    end
  end

  initial begin
    bus.req_i   = '0;
    bus.grant_i = '0;

    apply(16'h00F0, 2'b11, 16'h0000, 2'b11, "in_reset",       1'b1);
    apply(16'h0000, 2'b11, 16'h0000, 2'b00, "no_req",         1'b0);
    apply(16'h8001, 2'b11, 16'h8001, 2'b11, "wrap_pair",      1'b0);
    apply(16'h00F0, 2'b01, 16'h0010, 2'b11, "slot0_from0",    1'b0);
    apply(16'h00F0, 2'b01, 16'h0020, 2'b11, "slot0_from5",    1'b0);
    apply(16'h0004, 2'b11, 16'h0004, 2'b01, "single_req",     1'b0);
    apply(16'h0004, 2'b10, 16'h0000, 2'b01, "empty_slot_gnt", 1'b0);
    apply(16'h000F, 2'b10, 16'h0001, 2'b11, "slot1_wrap",     1'b0);
    apply(16'h000F, 2'b11, 16'h0006, 2'b11, "both_from1",     1'b0);
    apply(16'h0000, 2'b11, 16'h0000, 2'b00, "idle_again",     1'b0);
    apply(16'h0009, 2'b01, 16'h0008, 2'b11, "ptr3_pick3",     1'b0);
    apply(16'hFFFF, 2'b11, 16'h0030, 2'b11, "all_from4",      1'b0);
    apply(16'h8000, 2'b01, 16'h8000, 2'b01, "top_bit",        1'b0);
    apply(16'h0003, 2'b01, 16'h0001, 2'b11, "ptr_wrapped",    1'b0);
`ifdef SELECT_STARVE_GUARD_EN
    apply(16'h0008, 2'b01, 16'h0008, 2'b01, "st_ptr4",        1'b0);
    apply(16'h0001, 2'b00, 16'h0000, 2'b01, "st_age1",        1'b0);
    apply(16'h0001, 2'b00, 16'h0000, 2'b01, "st_age2",        1'b0);
    apply(16'h0001, 2'b00, 16'h0000, 2'b01, "st_age3",        1'b0);
    apply(16'h00FF, 2'b11, 16'h0011, 2'b11, "st_starved",     1'b0);
    apply(16'h00FF, 2'b01, 16'h0020, 2'b11, "st_ptr5",        1'b0);
`endif
    apply(16'h0100, 2'b01, 16'h0100, 2'b01, "ptr_to9",        1'b0);
    apply(16'h0200, 2'b01, 16'h0000, 2'b01, "mid_reset",      1'b1);
    apply(16'hFFFF, 2'b11, 16'h0003, 2'b11, "after_reset",    1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
